// File: rtl/memory_bank_sequencer_if.sv
// Bus bundle between the memory bank sequencer and its surroundings:
// host/DMA row load handshake, bank write/read ports and the skewed feed
// toward the systolic array. The sequencer uses the slave view; the
// environment (host, bank, array edge) uses the master view.
interface memory_bank_sequencer_if #(
  parameter int matrixSize = 4,
  parameter int dataSize   = 16
);
  localparam int locSize = (matrixSize > 1) ? $clog2(matrixSize) : 1;

  logic                       clear;
  logic                       loadValid;
  logic                       loadReady;
  logic signed [dataSize-1:0] loadRow [matrixSize];
  logic                       startDrain;
  logic                       busy;
  logic                       writeEnable;
  logic signed [dataSize-1:0] writeElementVector [matrixSize];
  logic [locSize-1:0]         writeLocationVector [matrixSize];
  logic [locSize-1:0]         readLocationVector [matrixSize];
  logic signed [dataSize-1:0] bankData [matrixSize];
  logic                       feedValid;
  logic [matrixSize-1:0]      feedLaneValid;
  logic signed [dataSize-1:0] feedVector [matrixSize];
  logic                       done;

  modport slave (
    input  clear, loadValid, loadRow, startDrain, bankData,
    output loadReady, busy, writeEnable, writeElementVector,
           writeLocationVector, readLocationVector,
           feedValid, feedLaneValid, feedVector, done
  );

  modport master (
    output clear, loadValid, loadRow, startDrain, bankData,
    input  loadReady, busy, writeEnable, writeElementVector,
           writeLocationVector, readLocationVector,
           feedValid, feedLaneValid, feedVector, done
  );
endinterface

// File: rtl/memory_bank_sequencer.sv
// Memory bank sequencer for the systolic array input edge.
// Loads an NxN matrix row by row into the per-column bank (location = row
// index) and drains it in skewed diagonal order: lane i lags lane i-1 by one
// cycle. The bank read is registered, so feed outputs trail each drain step
// by one cycle.
// Optional feature macro: MEMBANK_SEQ_REPEAT_EN -- when defined, FLUSH
// returns to FULL so the resident matrix can be drained repeatedly.
module memory_bank_sequencer #(
  parameter int matrixSize = 4,
  parameter int dataSize   = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  memory_bank_sequencer_if.slave  bus
);

  localparam int LocW     = (matrixSize > 1) ? $clog2(matrixSize) : 1;
  localparam int StepW    = (2 * matrixSize - 1 > 1) ? $clog2(2 * matrixSize - 1) : 1;
  localparam int LastRow  = matrixSize - 1;
  localparam int LastStep = 2 * matrixSize - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FULL,
    DRAIN,
    FLUSH
  } state_t;

  state_t                state;
  logic [LocW-1:0]       rowCount;
  logic [StepW-1:0]      drainCount;
  logic [matrixSize-1:0] laneMask;
  logic [matrixSize-1:0] feedMaskQ;
  logic                  feedValidQ;
  logic                  doneQ;
  logic                  beat;
  logic                  lastRow;
  logic                  lastStep;

  assign lastRow  = (rowCount == LocW'(LastRow));
  assign lastStep = (drainCount == StepW'(LastStep));

  // Load handshake and status decode; clear suppresses the write in its cycle
  assign bus.loadReady   = (state == IDLE) || (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign beat            = bus.loadValid && bus.loadReady && !bus.clear;
  assign bus.writeEnable = beat && resetN;

  assign bus.feedValid     = feedValidQ;
  assign bus.feedLaneValid = feedMaskQ;
  assign bus.done          = doneQ;

  // Bank write port: whole row at the current row index on every lane
  always_comb begin
    for (int unsigned i = 0; i < matrixSize; i++) begin
      bus.writeElementVector[i]  = bus.loadRow[i];
      bus.writeLocationVector[i] = rowCount;
    end
  end

  // Skewed read addressing: lane i reads location k-i when it falls inside
  // the bank; the difference is formed signed before truncation
  always_comb begin
    laneMask = '0;
    for (int unsigned i = 0; i < matrixSize; i++) begin
      bus.readLocationVector[i] = '0;
      if (state == DRAIN) begin
        if ((int'(drainCount) - int'(i) >= 0) &&
            (int'(drainCount) - int'(i) < matrixSize)) begin
          laneMask[i]               = 1'b1;
          bus.readLocationVector[i] = LocW'(int'(drainCount) - int'(i));
        end
      end
    end
  end

  // Feed data: bank output arrives with the registered mask; gate idle lanes
  always_comb begin
    for (int unsigned i = 0; i < matrixSize; i++) begin
      bus.feedVector[i] = feedMaskQ[i] ? bus.bankData[i] : '0;
    end
  end

  // Sequencer FSM with registered feed-valid, lane mask and done
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      rowCount   <= '0;
      drainCount <= '0;
      feedValidQ <= 1'b0;
      feedMaskQ  <= '0;
      doneQ      <= 1'b0;
    end else begin
      feedValidQ <= 1'b0;
      feedMaskQ  <= '0;
      doneQ      <= 1'b0;
      if (bus.clear) begin
        state      <= IDLE;
        rowCount   <= '0;
        drainCount <= '0;
      end else begin
        if (state == DRAIN) begin
          feedValidQ <= 1'b1;
          feedMaskQ  <= laneMask;
          doneQ      <= lastStep;
        end
        case (state)
          IDLE, LOAD: begin
            if (beat) begin
              if (lastRow) begin
                state    <= FULL;
                rowCount <= '0;
              end else begin
                state    <= LOAD;
                rowCount <= rowCount + LocW'(1);
              end
            end
          end
          FULL: begin
            if (bus.startDrain) begin
              state      <= DRAIN;
              drainCount <= '0;
            end
          end
          DRAIN: begin
            if (lastStep) begin
              state      <= FLUSH;
              drainCount <= '0;
            end else begin
              drainCount <= drainCount + StepW'(1);
            end
          end
          FLUSH: begin
`ifdef MEMBANK_SEQ_REPEAT_EN
            state <= FULL;
`else
            state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
